// File: rtl/shot_command_encoder_if.sv
// Scan-byte input and shot-command output bundle for shot_command_encoder.
// slave: the encoder side; master: keyboard receiver plus command consumer.
interface shot_command_encoder_if;
  logic       scan_valid;
  logic [7:0] scan_byte;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] letter;
  logic [3:0] number;
  logic       player_turn;
  logic [1:0] entry_state;

  modport slave (
    input  scan_valid, scan_byte, cmd_ready,
    output cmd_valid, letter, number, player_turn, entry_state
  );

  modport master (
    output scan_valid, scan_byte, cmd_ready,
    input  cmd_valid, letter, number, player_turn, entry_state
  );
endinterface

// File: rtl/shot_command_encoder.sv
// Turns PS/2 set-2 scan bytes into letter/number/Enter shot commands.
// Ports: clock27, reset_n (async low), bus (slave: scan in, cmd out).
module shot_command_encoder #(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic                  clock27,
  input  logic                  reset_n,
  shot_command_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_L  = 2'd1,
    HAVE_N  = 2'd2,
    PRESENT = 2'd3
  } state_e;

  localparam logic [7:0] K_BRK = 8'hF0;
  localparam logic [7:0] K_EXT = 8'hE0;
  localparam logic [7:0] K_ENT = 8'h5A;
  localparam logic [7:0] K_BSP = 8'h66;
  localparam logic [7:0] K_ESC = 8'h76;
  localparam logic [3:0] NONE  = 4'hF;

  state_e     state_q, state_d;
  logic [3:0] letter_q, letter_d;
  logic [3:0] number_q, number_d;
  logic       turn_q, turn_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;

  logic       key;
  logic       is_let, is_dig;
  logic [3:0] let_v, dig_v;
  logic       is_ent, is_bsp, is_esc;

  always_comb begin
    is_let = 1'b1;
    let_v  = 4'd0;
    case (bus.scan_byte)
      8'h1C: let_v = 4'd0;
      8'h32: let_v = 4'd1;
      8'h21: let_v = 4'd2;
      8'h23: let_v = 4'd3;
      8'h24: let_v = 4'd4;
      8'h2B: let_v = 4'd5;
      8'h34: let_v = 4'd6;
      8'h33: let_v = 4'd7;
      8'h43: let_v = 4'd8;
      8'h3B: let_v = 4'd9;
      default: is_let = 1'b0;
    endcase
  end

  always_comb begin
    is_dig = 1'b1;
    dig_v  = 4'd0;
    case (bus.scan_byte)
      8'h45: dig_v = 4'd0;
      8'h16: dig_v = 4'd1;
      8'h1E: dig_v = 4'd2;
      8'h26: dig_v = 4'd3;
      8'h25: dig_v = 4'd4;
      8'h2E: dig_v = 4'd5;
      8'h36: dig_v = 4'd6;
      8'h3D: dig_v = 4'd7;
      8'h3E: dig_v = 4'd8;
      8'h46: dig_v = 4'd9;
      default: is_dig = 1'b0;
    endcase
  end

  assign is_ent = (bus.scan_byte == K_ENT);
  assign is_bsp = (bus.scan_byte == K_BSP);
  assign is_esc = (bus.scan_byte == K_ESC);

  always_comb begin
    state_d  = state_q;
    letter_d = letter_q;
    number_d = number_q;
    turn_d   = turn_q;
    brk_d    = brk_q;
    ext_d    = ext_q;
    key      = 1'b0;

    // Prefix tracking is frozen while a command is presented.
    if (state_q != PRESENT && bus.scan_valid) begin
      if (bus.scan_byte == K_BRK) begin
        brk_d = 1'b1;
      end else if (bus.scan_byte == K_EXT) begin
        ext_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (ext_q) begin
        ext_d = 1'b0;
        key   = is_ent;
      end else begin
        key = 1'b1;
      end
    end

    if (state_q == PRESENT) begin
      if (bus.cmd_ready) begin
        state_d  = IDLE;
        letter_d = NONE;
        number_d = NONE;
        turn_d   = ~turn_q;
      end
    end else if (key && is_esc) begin
      state_d  = IDLE;
      letter_d = NONE;
      number_d = NONE;
    end else if (key) begin
      unique case (state_q)
        IDLE: begin
          if (is_let) begin
            letter_d = let_v;
            state_d  = HAVE_L;
          end
        end
        HAVE_L: begin
          if (is_let) begin
            letter_d = let_v;
          end else if (is_dig) begin
            number_d = dig_v;
            state_d  = HAVE_N;
          end else if (is_bsp) begin
            letter_d = NONE;
            state_d  = IDLE;
          end
        end
        HAVE_N: begin
          if (is_ent) begin
            state_d = PRESENT;
          end else if (is_dig) begin
            number_d = dig_v;
          end else if (is_bsp) begin
            number_d = NONE;
            state_d  = HAVE_L;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      letter_q <= NONE;
      number_q <= NONE;
      turn_q   <= FIRST_PLAYER;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      letter_q <= letter_d;
      number_q <= number_d;
      turn_q   <= turn_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
    end
  end

  assign bus.cmd_valid   = (state_q == PRESENT);
  assign bus.letter      = letter_q;
  assign bus.number      = number_q;
  assign bus.player_turn = turn_q;
  assign bus.entry_state = state_q;

endmodule

// File: doc/shot_command_encoder.md
# shot_command_encoder

Converts the raw PS/2 set-2 scan-byte stream from the keyboard receiver into complete shot commands (letter, number, player turn) for the shot-resolution logic. Each command is a letter key, then a digit key, then Enter. The block sits between the keyboard byte receiver and the board-update logic. It also owns the player-turn toggle, which advances once per accepted shot.

## Interface
- FIRST_PLAYER, default 0: value of `player_turn` after reset (0 = player one, 1 = player two).
- clock27  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- scan_valid  input  1  one-cycle strobe: `scan_byte` holds a new received byte.
- scan_byte  input  8  PS/2 set-2 byte (make code, 0xF0 break prefix or 0xE0 extended prefix).
- cmd_valid  output  1  a complete shot command is being presented.
- cmd_ready  input  1  the consumer accepts the command this cycle.
- letter  output  4  column code: A..J = 0..9. 0xF = no letter entered.
- number  output  4  row code: keys 1..9 = 1..9, key 0 (row ten) = 0. 0xF = no digit entered.
- player_turn  output  1  the player whose shot is being entered or presented.
- entry_state  output  2  0 = idle, 1 = have letter, 2 = have number, 3 = presenting. Drives the prompt display.

## Operation
- Prefix filter, applied before the FSM:
  - 0xF0 sets `brk`. The next non-prefix byte is discarded and clears `brk` and `ext`.
  - 0xE0 sets `ext`. A following non-F0 byte is discarded and clears `ext`, except 0x5A (keypad Enter), which is treated as Enter.
  - Only make codes with neither flag set, or keypad Enter, reach the FSM as a "key".
- Letter codes: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B map to 0..9.
- Digit codes: 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D, 8 3E, 9 46, 0 45.
- Control codes: Enter 5A, Backspace 66, Esc 76.
- FSM states and transitions:
  - IDLE: a letter key latches `letter` and goes to HAVE_L. Any other key is ignored.
  - HAVE_L:
    - A letter key overwrites `letter` and stays in HAVE_L.
    - A digit key latches `number` and goes to HAVE_N.
    - Backspace sets `letter` to 0xF and goes to IDLE.
    - Enter is ignored.
  - HAVE_N:
    - Enter goes to PRESENT.
    - A digit key overwrites `number` and stays.
    - Backspace sets `number` to 0xF and goes to HAVE_L.
    - A letter key is ignored.
  - PRESENT: `cmd_valid` = 1. `letter`, `number` and `player_turn` are held stable. Every key and prefix byte is dropped, and the prefix flags are not updated.
  - Esc in IDLE, HAVE_L or HAVE_N sets `letter` and `number` to 0xF and goes to IDLE.
- On handshake (`cmd_valid` & `cmd_ready` on a rising edge):
  - go to IDLE
  - `letter` and `number` become 0xF
  - `player_turn` inverts
- All outputs are registered. `entry_state` is the state encoding.

## Timing
- Reset (async assert, sync release) values:
  - `cmd_valid` = 0
  - `letter` = 0xF
  - `number` = 0xF
  - `player_turn` = FIRST_PLAYER
  - `entry_state` = 0
  - `brk` = 0, `ext` = 0
- Key latency: a key byte strobed in cycle n updates `letter`, `number` and `entry_state` at the edge ending cycle n, so the new values are visible in cycle n+1.
- Enter in HAVE_N strobed in cycle n gives `cmd_valid` = 1 in cycle n+1.
- `cmd_valid` stays high until it is accepted. A `cmd_ready` that is already high gives a one-cycle pulse.
- `cmd_ready` is ignored while `cmd_valid` = 0.
- A `scan_valid` in the same cycle as the handshake is dropped. The FSM is still PRESENT during that cycle.
- Back-to-back `scan_valid` on every cycle must be handled with no loss outside PRESENT.
- Reset mid-entry or mid-presentation discards the partial command. `player_turn` returns to FIRST_PLAYER.

## Test plan
- Basic shot:
  - Stimulus: reset, then bytes 32, F0, 32, 1E, F0, 1E, 5A, F0, 5A, with `cmd_ready` held 0.
  - Required: `cmd_valid` = 1 one cycle after the 5A make, with `letter` = 1, `number` = 2, `player_turn` = 0. Signals are stable for 10 cycles.
  - Then raise `cmd_ready` for one cycle. Required: `cmd_valid` = 0, `player_turn` = 1, `letter` = `number` = 0xF.
- Row ten and keypad Enter:
  - Stimulus: 3B, 45, E0, 5A with `cmd_ready` = 1.
  - Required: a single-cycle `cmd_valid` with `letter` = 9, `number` = 0.
- Editing:
  - Stimulus: 1C, 16, 66, 26, 5A.
  - Required: command with `letter` = 0, `number` = 3.
  - Stimulus: 1C, 76, 5A.
  - Required: `entry_state` = 0 and no `cmd_valid`.
- Ordering and filter:
  - Stimulus: 16 in IDLE, 5A in HAVE_L, then E0, 1C.
  - Required: all ignored, `entry_state` = 0.
  - Stimulus: F0, 1C.
  - Required: no letter latched.
- Presentation lockout:
  - Stimulus: while presenting with `cmd_ready` = 0, send 21, 26, 5A.
  - Required: outputs unchanged. After acceptance, `entry_state` = 0.
- Async reset:
  - Stimulus: assert `reset_n` low in HAVE_N and in PRESENT, mid-cycle.
  - Required: all outputs take their reset values immediately, before the next clock edge.
